// File: rtl/nibble_serial_add_arbiter.sv
// rtl/nibble_serial_add_arbiter.sv - two-requester round-robin arbiter over a shared 4-bit adder slice
// Operands are summed nibble by nibble, LSB first, through a registered carry.
module nibble_serial_add_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             busy,
  output logic             done,
  output logic             done_id,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int CW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [WIDTH-1:0] sum_work_q, sum_work_d;
  logic             carry_q, carry_d;
  logic             rr_q, rr_d;
  logic             winner_q, winner_d;
  logic             gnt0_q, gnt0_d;
  logic             gnt1_q, gnt1_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             done_id_q, done_id_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic [WIDTH-1:0] a_sh, b_sh;
  logic [4:0]       slice;
  logic             win;

  // The slice sees the current nibble of each operand shifted down to bit 0.
  assign a_sh  = op_a_q >> {cnt_q, 2'b00};
  assign b_sh  = op_b_q >> {cnt_q, 2'b00};
  assign slice = {1'b0, a_sh[3:0]} + {1'b0, b_sh[3:0]} + {4'b0000, carry_q};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    sum_work_d = sum_work_q;
    carry_d    = carry_q;
    rr_d       = rr_q;
    winner_d   = winner_q;
    gnt0_d     = 1'b0;
    gnt1_d     = 1'b0;
    done_d     = 1'b0;
    done_id_d  = done_id_q;
    sum_d      = sum_q;
    cout_d     = cout_q;
    win        = 1'b0;

    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          win      = (req0 && req1) ? rr_q : req1;
          winner_d = win;
          op_a_d   = win ? a1 : a0;
          op_b_d   = win ? b1 : b0;
          carry_d  = 1'b0;
          cnt_d    = '0;
          gnt0_d   = ~win;
          gnt1_d   = win;
          rr_d     = ~win;
          state_d  = ADD;
        end
      end
      ADD: begin
        sum_work_d[{cnt_q, 2'b00} +: 4] = slice[3:0];
        carry_d = slice[4];
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(NIBBLES - 1)) begin
          cnt_d     = '0;
          sum_d     = sum_work_d;
          cout_d    = slice[4];
          done_d    = 1'b1;
          done_id_d = winner_q;
          state_d   = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      sum_work_q <= '0;
      carry_q    <= 1'b0;
      rr_q       <= 1'b0;
      winner_q   <= 1'b0;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      done_id_q  <= 1'b0;
      sum_q      <= '0;
      cout_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      sum_work_q <= sum_work_d;
      carry_q    <= carry_d;
      rr_q       <= rr_d;
      winner_q   <= winner_d;
      gnt0_q     <= gnt0_d;
      gnt1_q     <= gnt1_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      done_id_q  <= done_id_d;
      sum_q      <= sum_d;
      cout_q     <= cout_d;
    end
  end

  assign gnt0    = gnt0_q;
  assign gnt1    = gnt1_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign done_id = done_id_q;
  assign sum     = sum_q;
  assign cout    = cout_q;

endmodule

// File: tb/tb_nibble_serial_add_arbiter.sv
// tb/tb_nibble_serial_add_arbiter.sv - bench for nibble_serial_add_arbiter
// Vector table, hand corner sequences and a randomized run against a queue-based model.
module tb_nibble_serial_add_arbiter;

  logic        clk, rst;
  logic        req0, req1;
  logic [15:0] a0, b0, a1, b1;
  logic        gnt0, gnt1, busy, done, done_id, cout;
  logic [15:0] sum;

  int n_total = 0;
  int n_pass  = 0;

  nibble_serial_add_arbiter #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .a0(a0), .b0(b0),
    .req1(req1), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .done(done),
    .done_id(done_id), .sum(sum), .cout(cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        id;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp_sum;
    logic        exp_cout;
  } vec_t;

  typedef struct {
    logic        id;
    logic [16:0] val;
  } exp_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Applies one lone request from IDLE and checks exact cycle-by-cycle timing.
  task automatic single_op(input vec_t v);
    if (v.id) begin req1 = 1'b1; a1 = v.a; b1 = v.b; end
    else begin req0 = 1'b1; a0 = v.a; b0 = v.b; end
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 1) begin
        chk("vec_gnt0", gnt0, !v.id);
        chk("vec_gnt1", gnt1, v.id);
        req0 = 1'b0;
        req1 = 1'b0;
      end
      chk("vec_busy", busy, (c <= 5));
      chk("vec_done", done, (c == 5));
      if (c >= 5) begin
        chk("vec_sum", sum, v.exp_sum);
        chk("vec_cout", cout, v.exp_cout);
        chk("vec_done_id", done_id, v.id);
      end
    end
  endtask

  task automatic wait_gnt(output logic id, output bit ok);
    ok = 1'b0;
    id = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (gnt0 || gnt1) begin
        ok = 1'b1;
        id = gnt1;
      end
    end
    chk("gnt_timeout", ok, 1);
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (done) ok = 1'b1;
    end
    chk("done_timeout", ok, 1);
  endtask

  vec_t vecs[6];
  exp_t q[$];

  initial begin
    logic gid;
    bit   ok;
    logic gnt1_seen;
    logic done_seen;
    logic rr_m, pred_v, pred_id;
    int   ndone, nraised;
    exp_t e;

    vecs[0] = '{1'b0, 16'h1234, 16'h1111, 16'h2345, 1'b0};
    vecs[1] = '{1'b1, 16'hFFFF, 16'h0001, 16'h0000, 1'b1};
    vecs[2] = '{1'b1, 16'h0FFF, 16'h0001, 16'h1000, 1'b0};
    vecs[3] = '{1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b1};
    vecs[4] = '{1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b0};
    vecs[5] = '{1'b0, 16'h8000, 16'h8000, 16'h0000, 1'b1};

    rst = 1'b1; req0 = 0; req1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0;
    repeat (3) @(negedge clk);
    chk("rst_gnt", {gnt0, gnt1}, 0);
    chk("rst_busy_done", {busy, done}, 0);
    chk("rst_sum", {cout, sum}, 0);
    chk("rst_done_id", done_id, 0);
    rst = 1'b0;

    // Tie from reset: 0 wins, held requester 1 follows, next tie goes to 0.
    req0 = 1; a0 = 16'h0003; b0 = 16'h0004;
    req1 = 1; a1 = 16'h0010; b1 = 16'h0020;
    wait_gnt(gid, ok);
    chk("tie1_id", gid, 0);
    req0 = 0;
    wait_done(ok);
    chk("tie1_done_id", done_id, 0);
    chk("tie1_sum", {cout, sum}, 17'h00007);
    wait_gnt(gid, ok);
    chk("tie2_id", gid, 1);
    req1 = 0;
    wait_done(ok);
    chk("tie2_done_id", done_id, 1);
    chk("tie2_sum", {cout, sum}, 17'h00030);
    @(negedge clk);
    req0 = 1; a0 = 16'h0001; b0 = 16'h0001;
    req1 = 1; a1 = 16'h0002; b1 = 16'h0002;
    wait_gnt(gid, ok);
    chk("tie3_id", gid, 0);
    req0 = 0; req1 = 0;
    wait_done(ok);
    chk("tie3_sum", {cout, sum}, 17'h00002);
    @(negedge clk);

    foreach (vecs[i]) single_op(vecs[i]);

    // Operand changes and a foreign request during ADD must not disturb the result.
    req0 = 1; a0 = 16'h0101; b0 = 16'h0202;
    gnt1_seen = 1'b0;
    done_seen = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (gnt1) gnt1_seen = 1'b1;
      if (c == 1) begin
        chk("hold_gnt0", gnt0, 1);
        req0 = 0; a0 = 16'hAAAA;
      end
      if (c == 2) begin req1 = 1; a1 = 16'h5555; b1 = 16'h5555; end
      if (c == 4) req1 = 0;
      if (c == 5) begin
        done_seen = done;
        chk("hold_sum", {cout, sum}, 17'h00303);
        chk("hold_done_id", done_id, 0);
      end
    end
    chk("hold_done", done_seen, 1);
    chk("hold_no_gnt1", gnt1_seen, 0);
    chk("hold_idle", busy, 0);

    // Async reset in cycle 3 of an ADD discards the operation.
    req0 = 1; a0 = 16'h0F0F; b0 = 16'h0101;
    @(negedge clk);
    req0 = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_outs", {gnt0, gnt1, busy, done, done_id, cout}, 0);
    chk("mid_rst_sum", sum, 0);
    @(negedge clk);
    rst = 1'b0;
    done_seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (done || busy) done_seen = 1'b1;
    end
    chk("mid_rst_no_done", done_seen, 0);
    req0 = 1; a0 = 16'h1111; b0 = 16'h2222;
    req1 = 1; a1 = 16'h3333; b1 = 16'h4444;
    wait_gnt(gid, ok);
    chk("post_rst_tie", gid, 0);
    req0 = 0; req1 = 0;
    wait_done(ok);
    chk("post_rst_sum", {cout, sum}, 17'h03333);

    // Randomized run: fresh reset so the model pointer starts favouring 0.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rr_m = 1'b0; pred_v = 1'b0; pred_id = 1'b0;
    ndone = 0; nraised = 0;
    for (int cyc = 0; cyc < 8000 && ndone < 200; cyc++) begin
      @(negedge clk);
      if (pred_v) begin
        chk("rnd_gnt0", gnt0, !pred_id);
        chk("rnd_gnt1", gnt1, pred_id);
        pred_v = 1'b0;
      end else begin
        chk("rnd_no_gnt", {gnt0, gnt1}, 0);
      end
      if (gnt0) begin
        q.push_back(exp_t'{1'b0, {1'b0, a0} + {1'b0, b0}});
        req0 = 0;
      end
      if (gnt1) begin
        q.push_back(exp_t'{1'b1, {1'b0, a1} + {1'b0, b1}});
        req1 = 0;
      end
      if (done) begin
        if (q.size() == 0) begin
          chk("rnd_spurious_done", 1, 0);
        end else begin
          e = q.pop_front();
          chk("rnd_done_id", done_id, e.id);
          chk("rnd_sum", {cout, sum}, e.val);
          ndone++;
        end
      end
      if (!req0 && nraised < 200 && $urandom_range(0, 2) == 0) begin
        req0 = 1; a0 = 16'($urandom); b0 = 16'($urandom); nraised++;
      end
      if (!req1 && nraised < 200 && $urandom_range(0, 2) == 0) begin
        req1 = 1; a1 = 16'($urandom); b1 = 16'($urandom); nraised++;
      end
      if (!busy && (req0 || req1)) begin
        pred_id = (req0 && req1) ? rr_m : req1;
        rr_m    = !pred_id;
        pred_v  = 1'b1;
      end
    end
    chk("rnd_all_done", ndone, 200);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
